// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle between the ALU operation decoder and
// the sequential divider.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Unsigned restoring divider, one quotient bit per clock through a single
// compare/subtract stage; start/busy/done handshake, quotient and remainder out.
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;        // dividend shifts out MSB-first, quotient shifts in LSB-side
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] part_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             zero_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_by_zero_reg;

  // The shifted partial remainder needs one extra bit; after a successful
  // subtract it is always below the divisor and fits back in WIDTH bits.
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  always_comb begin
    trial = {part_reg, acc_reg[WIDTH-1]};
    fits  = (trial >= {1'b0, divisor_reg});
    diff  = trial[WIDTH-1:0] - divisor_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      acc_reg         <= '0;
      divisor_reg     <= '0;
      part_reg        <= '0;
      cnt_reg         <= '0;
      zero_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            acc_reg     <= bus.dividend;
            divisor_reg <= bus.divisor;
            part_reg    <= '0;
            cnt_reg     <= CNT_W'(WIDTH - 1);
            zero_reg    <= (bus.divisor == '0);
            busy_reg    <= 1'b1;
            state_reg   <= (bus.divisor == '0) ? FIN : CALC;
          end
        end

        CALC: begin
          acc_reg  <= {acc_reg[WIDTH-2:0], fits};
          part_reg <= fits ? diff : trial[WIDTH-1:0];
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= FIN;
          end
        end

        FIN: begin
          // On the zero-divisor path acc_reg was never shifted and still holds the dividend.
          done_reg        <= 1'b1;
          busy_reg        <= 1'b0;
          quotient_reg    <= zero_reg ? '1 : acc_reg;
          remainder_reg   <= zero_reg ? acc_reg : part_reg;
          div_by_zero_reg <= zero_reg;
          state_reg       <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule
